// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//
// Read-side consumer for a FIFO with 1-cycle read latency. Owns the FIFO read
// port and re-presents the data as a first-word-fall-through valid/ready
// stream. A small circular skid buffer absorbs the read latency, so dout_ready
// never reaches rd combinationally and a steady stream moves 1 word/cycle.
//
// Parameters:
//   DW         data width (matches the FIFO word width)
//   BUF_DEPTH  skid buffer entries, 2..4 (3 or more for full throughput)
//   WCNT_W     width of the delivered-word counter (optional feature)
//
// Ports:
//   rdclk       block clock (FIFO read clock)
//   rst         asynchronous reset, active-high
//   empty       FIFO empty flag
//   q           FIFO read data, valid the cycle after rd
//   rd          FIFO read strobe
//   flush       synchronous flush of buffered and in-flight words
//   dout        stream data (buffer head)
//   dout_valid  stream valid
//   dout_ready  stream ready from downstream
//   occ         skid buffer occupancy, 0..BUF_DEPTH
//   wcnt        delivered-word counter (only with FIFO_RD_STREAM_WCNT_EN)
//
// Optional feature macro: FIFO_RD_STREAM_WCNT_EN adds the wcnt output, a
// free-running count of dout handshakes that wraps and survives flush.
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int DW        = 8,
    parameter int BUF_DEPTH = 3,
    parameter int WCNT_W    = 16
) (
    input  logic              rdclk,
    input  logic              rst,
    input  logic              empty,
    input  logic [DW-1:0]     q,
    output logic              rd,
    input  logic              flush,
    output logic [DW-1:0]     dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [2:0]        occ
`ifdef FIFO_RD_STREAM_WCNT_EN
   ,output logic [WCNT_W-1:0] wcnt
`endif
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    // Elaboration-time guard on the configuration.
    if (BUF_DEPTH < 2 || BUF_DEPTH > 4 || WCNT_W < 1) begin : g_bad_cfg
        $error("fifo_rd_stream: BUF_DEPTH must be 2..4 and WCNT_W >= 1");
    end

    logic [DW-1:0] mem_q [BUF_DEPTH];
    logic [DW-1:0] mem_d [BUF_DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [2:0]    occ_q, occ_d;
    logic          inflight_q, inflight_d;
    logic          capture, pop;

    // Circular increment; explicit wrap so non-power-of-2 depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Issue only when the word landing next cycle is guaranteed a slot:
    // buffered words plus the one already in flight must leave room.
    always_comb begin
        rd = !rst && !empty && !flush &&
             (({1'b0, occ_q} + {3'b000, inflight_q}) < 4'(BUF_DEPTH));
        inflight_d = rd;
    end

    assign dout_valid = (occ_q != 3'd0);
    assign dout       = mem_q[head_q];
    assign occ        = occ_q;

    always_comb begin
        capture = inflight_q && !flush;
        pop     = dout_valid && dout_ready && !flush;
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        occ_d   = occ_q;
        if (flush) begin
            // An in-flight word landing now is dropped with the rest.
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            if (capture) begin
                mem_d[tail_q] = q;
                tail_d        = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            occ_d = occ_q + {2'b00, capture} - {2'b00, pop};
        end
    end

    always_ff @(posedge rdclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef FIFO_RD_STREAM_WCNT_EN
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    // Counts every handshake seen downstream, including one coinciding
    // with a flush; flush itself leaves the count alone.
    always_comb begin
        wcnt_d = wcnt_q;
        if (dout_valid && dout_ready) wcnt_d = wcnt_q + WCNT_W'(1);
    end

    always_ff @(posedge rdclk or posedge rst) begin
        if (rst) wcnt_q <= '0;
        else     wcnt_q <= wcnt_d;
    end

    assign wcnt = wcnt_q;
`else
    // Delivered-word counter not built in this configuration.
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;
    localparam int DW = 8;
    localparam int BD = 3;
    localparam int WW = 4;

    logic          rdclk      = 1'b0;
    logic          rst        = 1'b1;
    logic          empty      = 1'b1;
    logic          flush      = 1'b0;
    logic          dout_ready = 1'b0;
    logic [DW-1:0] q          = '0;
    logic          rd, dout_valid;
    logic [DW-1:0] dout;
    logic [2:0]    occ;
`ifdef FIFO_RD_STREAM_WCNT_EN
    logic [WW-1:0] wcnt;
`endif

    fifo_rd_stream #(.DW(DW), .BUF_DEPTH(BD), .WCNT_W(WW)) dut (
        .rdclk(rdclk), .rst(rst), .empty(empty), .q(q), .rd(rd),
        .flush(flush), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .occ(occ)
`ifdef FIFO_RD_STREAM_WCNT_EN
       ,.wcnt(wcnt)
`endif
    );

    always #5 rdclk = ~rdclk;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] fifo_m[$];   // the FIFO itself
    logic [DW-1:0] exp_q[$];    // words read from the FIFO, not yet delivered
    int   cyc = 0, rd_cnt = 0, hs_cnt = 0, hs_base = 0;
    int   hs_first = -1, hs_last = -1, first_rd = -1, first_vld = -1;
    logic inflight_m = 1'b0;

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // One clock: sample what the coming edge will do, then play the FIFO.
    task automatic tick();
        logic rd_s, fl_s;
        logic [DW-1:0] w;
        @(negedge rdclk);
        rd_s = rd;
        fl_s = flush;
        if (rd_s) rd_cnt++;
        if (rd_s && first_rd < 0) first_rd = cyc;
        @(posedge rdclk);
        #1;
        cyc++;
        inflight_m = rd_s;
        if (fl_s) exp_q.delete();
        if (rd_s && fifo_m.size() > 0) begin
            w = fifo_m.pop_front();
            exp_q.push_back(w);
            q = w;
        end else begin
            q = DW'($urandom);
        end
        empty = (fifo_m.size() == 0);
    endtask

    task automatic wr(input logic [DW-1:0] w);
        fifo_m.push_back(w);
        empty = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_rd", int'(rd), 0);
        chk("rst_valid", int'(dout_valid), 0);
        chk("rst_occ", int'(occ), 0);
        chk("rst_dout", int'(dout), 0);
`ifdef FIFO_RD_STREAM_WCNT_EN
        chk("rst_wcnt", int'(wcnt), 0);
`endif
        exp_q.delete();
        inflight_m = 1'b0;
        hs_base = hs_cnt;
        tick();
        tick();
        #3 rst = 1'b0;
    endtask

    task automatic new_test();
        fifo_m.delete();
        empty = 1'b1;
        flush = 1'b0;
        dout_ready = 1'b0;
        do_reset();
        rd_cnt = 0; hs_first = -1; hs_last = -1; first_rd = -1; first_vld = -1;
    endtask

    task automatic preload();
        for (int i = 1; i <= 8; i++) wr(DW'(17 * i));
    endtask

    task automatic drain(input int limit, input bit toggle);
        int n = 0;
        while ((fifo_m.size() != 0 || exp_q.size() != 0) && n < limit) begin
            if (toggle) dout_ready = ~dout_ready;
            tick();
            n++;
        end
        chk("drain_left", exp_q.size() + fifo_m.size(), 0);
    endtask

    task automatic wait_valid(input int limit);
        int n = 0;
        while (!dout_valid && n < limit) begin
            tick();
            n++;
        end
        chk("valid_timeout", int'(dout_valid), 1);
    endtask

    // Monitor: checks every handshake against the scoreboard queue.
    task automatic mon();
        logic [DW-1:0] want;
        forever begin
            @(negedge rdclk);
            if (rst) begin
                chk("rd_in_reset", int'(rd), 0);
            end else begin
                chk("occ_range", int'(occ <= 3'(BD)), 1);
                chk("valid_vs_occ", int'(dout_valid), int'(occ != 0));
                chk("rd_rule", int'(rd && (empty || flush ||
                    (int'(occ) + int'(inflight_m) >= BD))), 0);
                if (dout_valid && first_vld < 0) first_vld = cyc;
                if (dout_valid && dout_ready) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = cyc;
                    hs_last = cyc;
                    if (exp_q.size() == 0) begin
                        chk("extra_word", exp_q.size(), 1);
                    end else begin
                        want = exp_q.pop_front();
                        chk("data", int'(dout), int'(want));
                    end
                end
            end
        end
    endtask

    task automatic run();
        int n;
        logic [DW-1:0] head;

        // streaming with downstream always ready
        new_test();
        dout_ready = 1'b1;
        preload();
        drain(40, 1'b0);
        chk("t1_latency", first_vld - first_rd, 2);
        chk("t1_count", hs_cnt - hs_base, 8);
        chk("t1_back2back", hs_last - hs_first, 7);

        // backpressure: buffer fills, then releases without gaps
        new_test();
        preload();
        for (int i = 0; i < 10; i++) tick();
        chk("t2_rd_pulses", rd_cnt, 3);
        chk("t2_occ", int'(occ), 3);
        chk("t2_head", int'(dout), 'h11);
        dout_ready = 1'b1;
        drain(40, 1'b0);
        chk("t2_count", hs_cnt - hs_base, 8);
        chk("t2_no_gap", hs_last - hs_first, 7);

        // toggling ready
        new_test();
        preload();
        drain(60, 1'b1);
        chk("t3_count", hs_cnt - hs_base, 8);

        // flush with occ=2 and a word in flight
        new_test();
        preload();
        n = 0;
        while (!(occ == 3'd2 && inflight_m) && n < 20) begin
            tick();
            n++;
        end
        chk("t4_setup", {occ, inflight_m}, {3'd2, 1'b1});
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_occ", int'(occ), 0);
        chk("t4_valid", int'(dout_valid), 0);
        chk("t4_fifo_left", fifo_m.size(), 5);
        dout_ready = 1'b1;
        wait_valid(10);
        chk("t4_resume", int'(dout), 'h44);
        drain(40, 1'b0);

        // asynchronous reset mid-stream
        new_test();
        preload();
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        do_reset();
        head = fifo_m[0];
        wait_valid(10);
        chk("t5_resume", int'(dout), int'(head));
        drain(40, 1'b0);

        // random traffic with occasional flushes
        new_test();
        for (int i = 0; i < 1500; i++) begin
            flush      = ($urandom_range(0, 31) == 0);
            dout_ready = ($urandom_range(0, 3) != 0);
            if (fifo_m.size() < 8 && $urandom_range(0, 2) != 0) wr(DW'($urandom));
            tick();
        end
        flush = 1'b0;
        dout_ready = 1'b1;
        drain(100, 1'b0);

`ifdef FIFO_RD_STREAM_WCNT_EN
        // counter wraps and survives flush
        new_test();
        dout_ready = 1'b1;
        n = 0;
        while (hs_cnt - hs_base < 20 && n < 200) begin
            if (fifo_m.size() < 8) wr(DW'(n));
            tick();
            n++;
        end
        dout_ready = 1'b0;
        chk("t7_hs", hs_cnt - hs_base, 20);
        chk("t7_wcnt", int'(wcnt), 4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t7_wcnt_flush", int'(wcnt), 4);
        dout_ready = 1'b1;
        drain(60, 1'b0);
        chk("t7_wcnt_end", int'(wcnt), (hs_cnt - hs_base) % 16);
`endif
    endtask

    initial begin
        fork
            mon();
            begin
                #500000;
                $display("FAIL watchdog actual=timeout expected=finish");
                $fatal(1);
            end
            run();
        join_any
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
